// File: rtl/zxuno_sram_pkg.sv
// Shared types and defaults for the SRAM arbiter.
package zxuno_sram_pkg;

    // Access sequencer states
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StAccess = 2'd2,
        StDone   = 2'd3
    } state_e;

    // Requester identifiers
    typedef enum logic [1:0] {
        ReqVid = 2'd0,
        ReqCpu = 2'd1,
        ReqDma = 2'd2
    } req_id_e;

    localparam int unsigned AccCyclesDefault   = 2;
    localparam int unsigned StarveLimitDefault = 8;

endpackage

// File: rtl/sram_grant_sel.sv
// Priority selection between video, CPU and DMA, with DMA starvation promotion.
module sram_grant_sel
    import zxuno_sram_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = StarveLimitDefault
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    vid_req,
    input  logic    cpu_req,
    input  logic    dma_req,
    input  logic    grant,     // a decision is being committed this cycle
    output logic    any_req,
    output req_id_e win_id
);

    localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

    logic [3:0] starve_q, starve_d;
    logic       dma_first;

    // Winner selection: video always first; DMA jumps CPU once starved
    always_comb begin
        any_req   = vid_req | cpu_req | dma_req;
        dma_first = (starve_q == Limit);
        win_id    = ReqVid;
        if (vid_req) begin
            win_id = ReqVid;
        end else if (dma_first && dma_req) begin
            win_id = ReqDma;
        end else if (cpu_req) begin
            win_id = ReqCpu;
        end else if (dma_req) begin
            win_id = ReqDma;
        end
    end

    // Starve counter: count DMA losses, saturate at the limit, clear on a DMA win
    always_comb begin
        starve_d = starve_q;
        if (grant && dma_req) begin
            if (win_id == ReqDma) begin
                starve_d = '0;
            end else if (starve_q != Limit) begin
                starve_d = starve_q + 4'd1;
            end
        end
    end

    // Starve counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Three-port arbiter sharing one asynchronous 8-bit SRAM (video, CPU, DMA).
module sram_arbiter
    import zxuno_sram_pkg::*;
#(
    parameter int unsigned ACC_CYCLES   = AccCyclesDefault,
    parameter int unsigned STARVE_LIMIT = StarveLimitDefault
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vid_req,
    input  logic [18:0] vid_addr,
    output logic        vid_ack,
    output logic [7:0]  vid_dout,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [18:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    output logic        cpu_ack,
    output logic [7:0]  cpu_dout,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [18:0] dma_addr,
    input  logic [7:0]  dma_din,
    output logic        dma_ack,
    output logic [7:0]  dma_dout,
    output logic [18:0] sram_addr,
    output logic [7:0]  sram_wdata,
    output logic        sram_drive,
    input  logic [7:0]  sram_rdata,
    output logic        sram_we_n
);

    state_e      state_q, state_d;
    req_id_e     id_q, id_d, win_id;
    logic        we_q, we_d;
    logic [18:0] addr_q, addr_d;
    logic [7:0]  din_q, din_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        grant, any_req, capture;
    logic        we_n_q, drive_q, vid_ack_q, cpu_ack_q, dma_ack_q;
    logic [7:0]  vid_dout_q, cpu_dout_q, dma_dout_q;

    sram_grant_sel #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_grant_sel (
        .clk     (clk),
        .rst_n   (rst_n),
        .vid_req (vid_req),
        .cpu_req (cpu_req),
        .dma_req (dma_req),
        .grant   (grant),
        .any_req (any_req),
        .win_id  (win_id)
    );

    // Next state and transaction latch
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        we_d    = we_q;
        addr_d  = addr_q;
        din_d   = din_q;
        grant   = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    grant   = 1'b1;
                    state_d = StSetup;
                    id_d    = win_id;
                    case (win_id)
                        ReqCpu: begin
                            we_d   = cpu_we;
                            addr_d = cpu_addr;
                            din_d  = cpu_din;
                        end
                        ReqDma: begin
                            we_d   = dma_we;
                            addr_d = dma_addr;
                            din_d  = dma_din;
                        end
                        default: begin
                            we_d   = 1'b0;
                            addr_d = vid_addr;
                            din_d  = '0;
                        end
                    endcase
                end
            end
            StSetup: begin
                state_d = StAccess;
                cnt_d   = '0;
            end
            StAccess: begin
                if (cnt_q == 3'(ACC_CYCLES - 1)) begin
                    state_d = StDone;
                    capture = ~we_q;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, latch and registered pad/ack outputs (decoded from next state so they never glitch)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            id_q      <= ReqVid;
            we_q      <= 1'b0;
            addr_q    <= '0;
            din_q     <= '0;
            we_n_q    <= 1'b1;
            drive_q   <= 1'b0;
            vid_ack_q <= 1'b0;
            cpu_ack_q <= 1'b0;
            dma_ack_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            id_q      <= id_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            we_n_q    <= ~((state_d == StAccess) && we_d);
            drive_q   <= (state_d != StIdle) && we_d;
            vid_ack_q <= (state_d == StDone) && (id_d == ReqVid);
            cpu_ack_q <= (state_d == StDone) && (id_d == ReqCpu);
            dma_ack_q <= (state_d == StDone) && (id_d == ReqDma);
        end
    end

    // Read data sampled from the pad at the end of the last ACCESS cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vid_dout_q <= '0;
            cpu_dout_q <= '0;
            dma_dout_q <= '0;
        end else if (capture) begin
            case (id_q)
                ReqVid:  vid_dout_q <= sram_rdata;
                ReqCpu:  cpu_dout_q <= sram_rdata;
                default: dma_dout_q <= sram_rdata;
            endcase
        end
    end

    assign sram_addr  = addr_q;
    assign sram_wdata = din_q;
    assign sram_drive = drive_q;
    assign sram_we_n  = we_n_q;
    assign vid_ack    = vid_ack_q;
    assign cpu_ack    = cpu_ack_q;
    assign dma_ack    = dma_ack_q;
    assign vid_dout   = vid_dout_q;
    assign cpu_dout   = cpu_dout_q;
    assign dma_dout   = dma_dout_q;

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter ACC_CYCLES, default 2: SRAM strobe cycles per access; legal range 1..7.
REQ-002 Parameter STARVE_LIMIT, default 8: consecutive DMA losses before DMA is promoted above CPU.
REQ-003 Port clk, in, 1: 28 MHz system clock, the only clock.
REQ-004 Port rst_n, in, 1: reset, asynchronous and active-low.
REQ-005 Port vid_req, in, 1: video fetch request, level, held until vid_ack.
REQ-006 Port vid_addr, in, 19: video read address.
REQ-007 Port vid_ack, out, 1: one-cycle completion pulse.
REQ-008 Port vid_dout, out, 8: video read data.
REQ-009 Ports cpu_req/cpu_we/cpu_addr/cpu_din, in, 1/1/19/8: CPU request, write flag, address, write data.
REQ-010 Ports cpu_ack/cpu_dout, out, 1/8: CPU completion pulse and read data.
REQ-011 Ports dma_req/dma_we/dma_addr/dma_din, in, 1/1/19/8: DMA/boot-loader request set, same semantics as CPU.
REQ-012 Ports dma_ack/dma_dout, out, 1/8: DMA completion pulse and read data.
REQ-013 Port sram_addr, out, 19: SRAM address.
REQ-014 Port sram_wdata, out, 8: write data toward the pad.
REQ-015 Port sram_drive, out, 1: pad output enable; 1 drives sram_wdata.
REQ-016 Port sram_rdata, in, 8: data from the pad.
REQ-017 Port sram_we_n, out, 1: SRAM write strobe, active low.

Function
REQ-018 The FSM SHALL have states IDLE, SETUP, ACCESS, DONE.
REQ-019 In IDLE, with any request high, the FSM SHALL latch the winner's id, addr, we and din, then enter SETUP on the next edge.
REQ-020 Priority SHALL be video > CPU > DMA; when the starve counter equals STARVE_LIMIT, it SHALL be video > DMA > CPU.
REQ-021 The 4-bit starve counter SHALL increment, saturating at STARVE_LIMIT, on each IDLE grant where DMA is requesting and loses.
REQ-022 The starve counter SHALL clear to 0 on each DMA grant.
REQ-023 SETUP SHALL last 1 cycle: sram_addr valid, sram_we_n=1, and sram_drive=we.
REQ-024 ACCESS SHALL last ACC_CYCLES cycles; sram_we_n SHALL be 0 throughout ACCESS for writes and 1 for reads.
REQ-025 For reads, sram_rdata SHALL be registered on the last ACCESS cycle.
REQ-026 DONE SHALL last 1 cycle with sram_we_n=1, and sram_addr/sram_wdata/sram_drive held for write hold time.
REQ-027 In DONE, exactly one of the winner's ack signals SHALL pulse.
REQ-028 In DONE, the winner's dout SHALL update for reads.
REQ-029 After DONE, the FSM SHALL return to IDLE.
REQ-030 Latency SHALL be ACC_CYCLES+2 cycles from the IDLE grant edge to ack.
REQ-031 Back-to-back period SHALL be ACC_CYCLES+3 cycles.
REQ-032 Each port's dout SHALL hold its value until that port's next completed read; writes SHALL NOT change dout.
REQ-033 If a requester drops req mid-transaction, the transaction SHALL complete and the ack SHALL still pulse.
REQ-034 A req still high in the cycle after its ack SHALL be treated as a new request.
REQ-035 Requests arriving outside IDLE SHALL wait; no pre-emption of an in-flight access SHALL occur.
REQ-036 Addresses SHALL pass through unmodified, 19 bits, with no wrap logic.
REQ-037 In IDLE, sram_addr SHALL hold its last value, sram_drive=0, and sram_we_n=1.

Reset
REQ-038 rst_n low SHALL immediately force state IDLE, sram_we_n=1, sram_drive=0, and all acks 0, regardless of clk.
REQ-039 rst_n low SHALL immediately force sram_addr=0, sram_wdata=0, all dout=0, and starve counter=0.
REQ-040 Reset asserted mid-write SHALL abort the write with no ack.

Structure
REQ-041 Package zxuno_sram_pkg SHALL hold the state encoding, requester ids (VID=0, CPU=1, DMA=2), and the defaults for ACC_CYCLES and STARVE_LIMIT.
REQ-042 A single sub-module, sram_grant_sel, SHALL contain the priority selection and the starve counter; the FSM and datapath registers SHALL remain in sram_arbiter.

Verification
REQ-043 CPU write: addr 0x12345, data 0xA5, ACC_CYCLES=2 -> sram_we_n low exactly 2 cycles; cpu_ack 4 cycles after grant; the pad holds 0xA5 through DONE.
REQ-044 CPU read of 0x12345 after that write -> cpu_dout=0xA5 coincident with cpu_ack; vid_dout and dma_dout unchanged.
REQ-045 vid_req, cpu_req, dma_req raised in the same cycle -> grant order video, CPU, DMA; acks 5 cycles apart.
REQ-046 cpu_req held continuously with dma_req high -> DMA is granted on the 9th decision, then the counter returns to 0.
REQ-047 rst_n pulled low on the first ACCESS cycle of a write -> sram_we_n=1 asynchronously, no ack, FSM in IDLE; the first request after release completes normally.
REQ-048 cpu_req dropped during SETUP -> cpu_ack still pulses once, and no second access starts.
